// File: rtl/watch_display_master.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | watch_display_master                                                      |
// | Keeps HH:MM:SS time and bursts it to a 9-register 7-segment display slave.|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module watch_display_master #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] master_address,
  output logic       master_write,
  output logic [7:0] master_writedata,
  input  logic       master_waitrequest,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic [1:0] edit_sel,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       busy
);

  localparam logic [CNT_W-1:0] C_TICK_LAST = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]       C_DASH      = 8'hBF;
  localparam logic [3:0]       C_LAST_REG  = 4'd8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WR   = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_presc;
  logic             r_pending;
  logic [1:0]       r_edit_q;
  logic [7:0]       r_frame [0:8];

  logic             w_tick;
  logic             w_sec_wrap;
  logic             w_min_step;
  logic             w_min_wrap;
  logic             w_hour_step;
  logic             w_event;
  logic             w_start;
  logic [7:0]       w_h_bcd;
  logic [7:0]       w_m_bcd;
  logic [7:0]       w_s_bcd;
  logic [7:0]       w_frame [0:8];

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Tens/ones split by a compare ladder; values never exceed 59.
  function automatic logic [7:0] bcd_split(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    if (v >= 6'd50) begin
      t = 4'd5; r = v - 6'd50;
    end else if (v >= 6'd40) begin
      t = 4'd4; r = v - 6'd40;
    end else if (v >= 6'd30) begin
      t = 4'd3; r = v - 6'd30;
    end else if (v >= 6'd20) begin
      t = 4'd2; r = v - 6'd20;
    end else if (v >= 6'd10) begin
      t = 4'd1; r = v - 6'd10;
    end else begin
      t = 4'd0; r = v;
    end
    return {t, 4'(r)};
  endfunction

  assign w_tick      = (r_presc == C_TICK_LAST);
  assign w_sec_wrap  = w_tick && (seconds == 6'd59);
  // A button press and a carry landing in the same cycle count as one step.
  assign w_min_step  = inc_min || w_sec_wrap;
  assign w_min_wrap  = w_sec_wrap && (minutes == 6'd59);
  assign w_hour_step = inc_hour || w_min_wrap;
  assign w_event     = w_tick || inc_hour || inc_min || (edit_sel != r_edit_q);
  assign w_start     = (r_state == S_IDLE) && r_pending;

  always_comb begin
    w_h_bcd    = bcd_split({1'b0, hours});
    w_m_bcd    = bcd_split(minutes);
    w_s_bcd    = bcd_split(seconds);
    w_frame[0] = seg7(w_h_bcd[7:4]);
    w_frame[1] = seg7(w_h_bcd[3:0]);
    w_frame[2] = C_DASH;
    w_frame[3] = seg7(w_m_bcd[7:4]);
    w_frame[4] = seg7(w_m_bcd[3:0]);
    w_frame[5] = C_DASH;
    w_frame[6] = seg7(w_s_bcd[7:4]);
    w_frame[7] = seg7(w_s_bcd[3:0]);
    case (edit_sel)
      2'b01:   w_frame[8] = 8'h03;
      2'b10:   w_frame[8] = 8'h18;
      default: w_frame[8] = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
      if (w_tick) begin
        seconds <= (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
      end
      if (w_min_step) begin
        minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
      end
      if (w_hour_step) begin
        hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
      end
    end
  end

  // The frame is captured once per burst so one burst never mixes two times.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_pending        <= 1'b1;
      r_edit_q         <= 2'b00;
      master_write     <= 1'b0;
      master_address   <= 4'd0;
      master_writedata <= 8'h00;
      busy             <= 1'b0;
      for (int i = 0; i < 9; i++) r_frame[i] <= 8'h00;
    end else begin
      r_edit_q  <= edit_sel;
      r_pending <= w_event || (r_pending && !w_start);
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            for (int i = 0; i < 9; i++) r_frame[i] <= w_frame[i];
            r_state          <= S_WR;
            master_write     <= 1'b1;
            master_address   <= 4'd0;
            master_writedata <= w_frame[0];
            busy             <= 1'b1;
          end
        end
        S_WR: begin
          if (!master_waitrequest) begin
            if (master_address == C_LAST_REG) begin
              r_state      <= S_IDLE;
              master_write <= 1'b0;
              busy         <= 1'b0;
            end else begin
              master_address   <= master_address + 4'd1;
              master_writedata <= r_frame[master_address + 4'd1];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_watch_display_master.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for watch_display_master: time model plus write scoreboard, directed steps.
module tb_watch_display_master;

  localparam int TPS = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] master_address;
  logic       master_write;
  logic [7:0] master_writedata;
  logic       master_waitrequest = 1'b0;
  logic       inc_hour = 1'b0;
  logic       inc_min = 1'b0;
  logic [1:0] edit_sel = 2'b00;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       busy;

  always #5 clk = ~clk;

  watch_display_master #(.TICKS_PER_SEC(TPS), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .master_address(master_address), .master_write(master_write),
    .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
    .inc_hour(inc_hour), .inc_min(inc_min), .edit_sel(edit_sel),
    .hours(hours), .minutes(minutes), .seconds(seconds), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference time model; s_* hold the values seen just before each edge.
  int m_cnt, m_h, m_m, m_s, s_h, s_m, s_s;
  logic [1:0] s_edit;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_h <= 0; m_m <= 0; m_s <= 0;
      s_h <= 0; s_m <= 0; s_s <= 0; s_edit <= 2'b00;
    end else begin
      int ns, nm, nh;
      bit tk, cm, ch;
      tk = (m_cnt == TPS - 1);
      ns = m_s; nm = m_m; nh = m_h; cm = 0; ch = 0;
      if (tk) begin
        if (m_s == 59) begin ns = 0; cm = 1; end else ns = m_s + 1;
      end
      if (inc_min || cm) begin
        nm = (m_m + 1) % 60;
        ch = cm && (m_m == 59);
      end
      if (inc_hour || ch) nh = (m_h + 1) % 24;
      s_h <= m_h; s_m <= m_m; s_s <= m_s; s_edit <= edit_sel;
      m_cnt <= tk ? 0 : m_cnt + 1;
      m_s <= ns; m_m <= nm; m_h <= nh;
    end
  end

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; 9: return 8'h90; default: return 8'hFF;
    endcase
  endfunction

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;

  function automatic wr_t exp_wr(input int i, input int h, input int m, input int s,
                                 input logic [1:0] e);
    wr_t w;
    w.a = 4'(i);
    case (i)
      0: w.d = seg(h / 10);
      1: w.d = seg(h % 10);
      3: w.d = seg(m / 10);
      4: w.d = seg(m % 10);
      6: w.d = seg(s / 10);
      7: w.d = seg(s % 10);
      8: w.d = (e == 2'b01) ? 8'h03 : (e == 2'b10) ? 8'h18 : 8'h00;
      default: w.d = 8'hBF;
    endcase
    return w;
  endfunction

  wr_t q[$];
  wr_t e;
  logic prev_wr = 1'b0;
  int start_cnt = 0, done_cnt = 0, run = 0, last_len = 0;
  logic [7:0] last_frame [0:8];

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      prev_wr = 1'b0;
      run = 0;
      start_cnt = done_cnt;
      for (int i = 0; i < 9; i++) last_frame[i] = 8'h00;
    end else begin
      check("hours", hours, m_h);
      check("minutes", minutes, m_m);
      check("seconds", seconds, m_s);
      if (master_write && !prev_wr) begin
        check("sb_leftover", q.size(), 0);
        start_cnt++;
        for (int i = 0; i < 9; i++) q.push_back(exp_wr(i, s_h, s_m, s_s, s_edit));
      end
      if (master_write) run = prev_wr ? run + 1 : 1;
      if (master_write && !master_waitrequest) begin
        e = (q.size() > 0) ? q.pop_front() : wr_t'{a: 4'hF, d: 8'h00};
        check("sb_addr", master_address, e.a);
        check("sb_data", master_writedata, e.d);
        if (master_address < 4'd9) last_frame[master_address] = master_writedata;
      end
      if (!master_write && prev_wr) begin
        done_cnt++;
        last_len = run;
      end
      prev_wr = master_write;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    while (done_cnt < target && k < 400) begin
      @(negedge clk); #1; k++;
    end
    check({tag, "_timeout"}, done_cnt >= target, 1);
  endtask

  task automatic wait_fresh_burst(input string tag);
    wait_done(start_cnt + 1, tag);
  endtask

  task automatic pulse_hour(input int n);
    for (int i = 0; i < n; i++) begin inc_hour = 1'b1; step(); inc_hour = 1'b0; step(); end
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin inc_min = 1'b1; step(); inc_min = 1'b0; step(); end
  endtask

  task automatic wait_model(input int sec, input bool_last, input string tag);
    int k = 0;
    while (!(m_s == sec && (!bool_last || m_cnt == TPS - 1)) && k < 1500) begin
      step(); k++;
    end
    check({tag, "_timeout"}, k < 1500, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_write", master_write, 0);
    check("rst_addr", master_address, 0);
    check("rst_data", master_writedata, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // First burst starts on the first edge after release.
    step();
    check("first_write", master_write, 1);
    check("first_addr", master_address, 0);
    check("first_busy", busy, 1);
    wait_done(1, "burst0");
    check("burst0_len", last_len, 9);
    check("burst0_busy", busy, 0);
    check("burst0_reg7", last_frame[7], 8'hC0);
    check("burst0_reg8", last_frame[8], 8'h00);

    // Tick landed during burst 0: one idle cycle, then a follow-up burst.
    step();
    check("burst1_write", master_write, 1);
    check("burst1_addr", master_address, 0);
    repeat (3) step();
    check("stall_start_addr", master_address, 3);
    master_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_write", master_write, 1);
      check("stall_addr", master_address, 3);
      check("stall_data", master_writedata, 8'hC0);
    end
    master_waitrequest = 1'b0;
    wait_done(2, "burst1");
    check("burst1_len", last_len, 14);
    check("burst1_reg7", last_frame[7], 8'hF9);

    // Blink mask follows edit_sel.
    step();
    edit_sel = 2'b01; step();
    wait_fresh_burst("edit01");
    check("mask01", last_frame[8], 8'h03);
    step();
    edit_sel = 2'b10; step();
    wait_fresh_burst("edit10");
    check("mask10", last_frame[8], 8'h18);
    step();
    edit_sel = 2'b11; step();
    wait_fresh_burst("edit11");
    check("mask11", last_frame[8], 8'h00);
    step();
    edit_sel = 2'b00;

    // inc_min at 59 wraps without touching hours.
    pulse_hour(5);
    pulse_min(59);
    check("pre_wrap_h", hours, 5);
    check("pre_wrap_m", minutes, 59);
    inc_min = 1'b1; step(); inc_min = 1'b0;
    check("min_wrap_m", minutes, 0);
    check("min_wrap_h", hours, 5);
    wait_fresh_burst("minwrap");
    check("minwrap_reg1", last_frame[1], 8'h92);
    check("minwrap_reg3", last_frame[3], 8'hC0);
    check("minwrap_reg4", last_frame[4], 8'hC0);

    // inc_min coinciding with a tick minute-carry advances minutes once.
    step();
    wait_model(59, 1, "merge");
    inc_min = 1'b1; step(); inc_min = 1'b0;
    check("merge_m", minutes, 1);
    check("merge_s", seconds, 0);
    check("merge_h", hours, 5);

    // 23:59:59 + tick rolls over to 00:00:00.
    pulse_hour(18);
    pulse_min(58);
    wait_model(59, 0, "to59");
    check("t235959_h", hours, 23);
    check("t235959_m", minutes, 59);
    check("t235959_s", seconds, 59);
    wait_model(0, 0, "wrap");
    check("wrap_h", hours, 0);
    check("wrap_m", minutes, 0);
    check("wrap_s", seconds, 0);
    wait_fresh_burst("wrapburst");
    for (int i = 0; i < 8; i++) begin
      if (i != 2 && i != 5) check("wrap_digit", last_frame[i], 8'hC0);
    end

    // Reset in the middle of a burst drops the write at once.
    begin
      int k = 0;
      step();
      while (!(master_write && master_address == 4'd4) && k < 200) begin step(); k++; end
      check("midburst_timeout", k < 200, 1);
    end
    #1 reset = 1'b1;
    #1;
    check("async_write", master_write, 0);
    check("async_busy", busy, 0);
    repeat (2) step();
    reset = 1'b0;
    step();
    check("restart_write", master_write, 1);
    check("restart_addr", master_address, 0);
    wait_done(done_cnt + 1, "restart");
    check("restart_len", last_len, 9);
    check("restart_reg0", last_frame[0], 8'hC0);
    check("restart_reg7", last_frame[7], 8'hC0);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
